// File: rtl/nibble_rx_if.sv
// Serial nibble receive bus: line input plus the parallel load port it drives.
interface nibble_rx_if;
  logic       rx;
  logic [3:0] d;
  logic       load;
  logic       err;
  logic       busy;

  modport master (output rx, input d, load, err, busy);
  modport slave  (input rx, output d, load, err, busy);
endinterface

// File: rtl/nibble_rx.sv
// Framed serial nibble receiver (start, 4 data LSB first, [parity], stop) feeding a load register.
// Define NIBBLE_RX_PARITY_EN to expect an even-parity bit after data bit 3.
module nibble_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        rstn,
  nibble_rx_if.slave bus
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
`ifdef NIBBLE_RX_PARITY_EN
    ,
    StParity   = 3'd5
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      sr_q, sr_d;
  logic [3:0]      d_q, d_d;
  logic            load_q, load_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
`ifdef NIBBLE_RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      d_q       <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      d_q       <= d_d;
      load_q    <= load_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef NIBBLE_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntOne;
    idx_d     = idx_q;
    sr_d      = sr_q;
    d_d       = d_q;
    load_d    = 1'b0;
    err_d     = 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef NIBBLE_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!bus.rx) state_d = StStart;
      end
      StStart: begin
        // Mid-bit re-check: a start that has gone high again is a glitch, not an error.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = bus.rx ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          sr_d  = {bus.rx, sr_q[3:1]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef NIBBLE_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef NIBBLE_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_err_d = ^{bus.rx, sr_q};
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (!bus.rx) begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
`ifdef NIBBLE_RX_PARITY_EN
          else if (par_err_q) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
`endif
          else begin
            d_d     = sr_q;
            load_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitHigh: begin
        // A line held low after a bad stop must not be mistaken for a new start bit.
        cnt_d = '0;
        if (bus.rx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  assign bus.d    = d_q;
  assign bus.load = load_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_nibble_rx.sv
// Directed self-checking bench for nibble_rx with N = 4; tracks parity build via NIBBLE_RX_PARITY_EN.
module tb_nibble_rx;

  localparam int unsigned N = 4;
`ifdef NIBBLE_RX_PARITY_EN
  localparam int unsigned FrameBits = 7;
`else
  localparam int unsigned FrameBits = 6;
`endif
  // Cycles from driving the start bit to the cycle in which load is visible.
  localparam int LoadLat = 1 + N / 2 + (FrameBits - 1) * N;
  localparam int HistLen = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       load_hist [HistLen];
  logic       err_hist  [HistLen];
  logic       busy_hist [HistLen];
  logic [3:0] d_hist    [HistLen];

`ifdef NIBBLE_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  nibble_rx_if bus ();

  nibble_rx #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HistLen) begin
      load_hist[cyc] <= bus.load;
      err_hist[cyc]  <= bus.err;
      busy_hist[cyc] <= bus.busy;
      d_hist[cyc]    <= bus.d;
    end
  end

  function automatic int count_load(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (load_hist[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_err(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (err_hist[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame, N cycles per bit; p is the cycle in which the start bit was driven.
  task automatic send_frame(input logic [3:0] data, input logic stop_bit, output int p);
    p = cyc;
    bus.rx = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      bus.rx = data[i];
      tick(N);
    end
`ifdef NIBBLE_RX_PARITY_EN
    bus.rx = (^data) ^ par_flip;
    tick(N);
`endif
    bus.rx = stop_bit;
    tick(N);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    rstn   = 1'b0;
    tick(3);
    n_cmp++; if (bus.d !== 4'h0)  begin n_bad++; $display("FAIL reset_d got %0h want 0", bus.d); end
    n_cmp++; if (bus.load !== 1'b0) begin n_bad++; $display("FAIL reset_load got %0b want 0", bus.load); end
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL reset_err got %0b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    rstn = 1'b1;
    tick(3);
  endtask

  task automatic test_good_frame();
    int p;
    send_frame(4'h5, 1'b1, p);
    tick(4);
    n_cmp++; if (count_load(p, cyc - 1) !== 1) begin
      n_bad++; $display("FAIL good_load_count got %0d want 1", count_load(p, cyc - 1)); end
    n_cmp++; if (load_hist[p + LoadLat] !== 1'b1) begin
      n_bad++; $display("FAIL good_load_time got %0b want 1", load_hist[p + LoadLat]); end
    n_cmp++; if (d_hist[p + LoadLat] !== 4'h5) begin
      n_bad++; $display("FAIL good_d_at_load got %0h want 5", d_hist[p + LoadLat]); end
    n_cmp++; if (d_hist[p + LoadLat - 1] !== 4'h0) begin
      n_bad++; $display("FAIL good_d_before_load got %0h want 0", d_hist[p + LoadLat - 1]); end
    n_cmp++; if (count_err(p, cyc - 1) !== 0) begin
      n_bad++; $display("FAIL good_err_count got %0d want 0", count_err(p, cyc - 1)); end
    n_cmp++; if (busy_hist[p + 1] !== 1'b1) begin
      n_bad++; $display("FAIL good_busy_rise got %0b want 1", busy_hist[p + 1]); end
    n_cmp++; if (busy_hist[p + LoadLat - 1] !== 1'b1) begin
      n_bad++; $display("FAIL good_busy_hold got %0b want 1", busy_hist[p + LoadLat - 1]); end
    n_cmp++; if (busy_hist[p + LoadLat] !== 1'b0) begin
      n_bad++; $display("FAIL good_busy_fall got %0b want 0", busy_hist[p + LoadLat]); end
  endtask

  task automatic test_glitch();
    int p;
    p = cyc;
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    tick(8);
    n_cmp++; if (busy_hist[p + 1] !== 1'b1) begin
      n_bad++; $display("FAIL glitch_busy_rise got %0b want 1", busy_hist[p + 1]); end
    n_cmp++; if (busy_hist[p + 4] !== 1'b0) begin
      n_bad++; $display("FAIL glitch_busy_drop got %0b want 0", busy_hist[p + 4]); end
    n_cmp++; if (count_load(p, cyc - 1) + count_err(p, cyc - 1) !== 0) begin
      n_bad++; $display("FAIL glitch_pulses got %0d want 0", count_load(p, cyc - 1) + count_err(p, cyc - 1)); end
    n_cmp++; if (bus.d !== 4'h5) begin n_bad++; $display("FAIL glitch_d got %0h want 5", bus.d); end
  endtask

  task automatic test_framing();
    int p;
    int p2;
    send_frame(4'h9, 1'b0, p);
    tick(8);
    n_cmp++; if (err_hist[p + LoadLat] !== 1'b1) begin
      n_bad++; $display("FAIL frame_err_time got %0b want 1", err_hist[p + LoadLat]); end
    n_cmp++; if (count_err(p, cyc - 1) !== 1) begin
      n_bad++; $display("FAIL frame_err_count got %0d want 1", count_err(p, cyc - 1)); end
    n_cmp++; if (count_load(p, cyc - 1) !== 0) begin
      n_bad++; $display("FAIL frame_load_count got %0d want 0", count_load(p, cyc - 1)); end
    n_cmp++; if (bus.d !== 4'h5) begin n_bad++; $display("FAIL frame_d_kept got %0h want 5", bus.d); end
    n_cmp++; if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL frame_wait_high_busy got %0b want 1", bus.busy); end
    bus.rx = 1'b1;
    tick(2);
    n_cmp++; if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL frame_release_busy got %0b want 0", bus.busy); end
    send_frame(4'hC, 1'b1, p2);
    tick(2);
    n_cmp++; if (load_hist[p2 + LoadLat] !== 1'b1) begin
      n_bad++; $display("FAIL frame_next_load got %0b want 1", load_hist[p2 + LoadLat]); end
    n_cmp++; if (bus.d !== 4'hC) begin n_bad++; $display("FAIL frame_next_d got %0h want c", bus.d); end
  endtask

  task automatic test_back_to_back();
    int p1;
    int p2;
    send_frame(4'hC, 1'b1, p1);
    send_frame(4'h9, 1'b1, p2);
    tick(4);
    n_cmp++; if (count_load(p1, cyc - 1) !== 2) begin
      n_bad++; $display("FAIL b2b_load_count got %0d want 2", count_load(p1, cyc - 1)); end
    n_cmp++; if (load_hist[p1 + LoadLat] !== 1'b1 || load_hist[p1 + LoadLat + FrameBits * N] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_load_spacing got %0b%0b want 11",
                        load_hist[p1 + LoadLat], load_hist[p1 + LoadLat + FrameBits * N]); end
    n_cmp++; if (d_hist[p1 + LoadLat] !== 4'hC) begin
      n_bad++; $display("FAIL b2b_first_d got %0h want c", d_hist[p1 + LoadLat]); end
    n_cmp++; if (d_hist[p1 + LoadLat + FrameBits * N] !== 4'h9) begin
      n_bad++; $display("FAIL b2b_second_d got %0h want 9", d_hist[p1 + LoadLat + FrameBits * N]); end
    n_cmp++; if (count_err(p1, cyc - 1) !== 0) begin
      n_bad++; $display("FAIL b2b_err_count got %0d want 0", count_err(p1, cyc - 1)); end
  endtask

  task automatic test_reset_mid();
    int p;
    bus.rx = 1'b0;
    tick(N);
    bus.rx = 1'b0;
    tick(N);
    bus.rx = 1'b1;
    tick(N);
    bus.rx = 1'b1;
    tick(2);
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus.d !== 4'h0)  begin n_bad++; $display("FAIL midrst_d got %0h want 0", bus.d); end
    n_cmp++; if (bus.load !== 1'b0) begin n_bad++; $display("FAIL midrst_load got %0b want 0", bus.load); end
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL midrst_err got %0b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %0b want 0", bus.busy); end
    tick(2);
    rstn = 1'b1;
    tick(3);
    send_frame(4'h3, 1'b1, p);
    tick(2);
    n_cmp++; if (bus.d !== 4'h3) begin n_bad++; $display("FAIL midrst_next_d got %0h want 3", bus.d); end
    n_cmp++; if (count_load(p, cyc - 1) !== 1) begin
      n_bad++; $display("FAIL midrst_load_count got %0d want 1", count_load(p, cyc - 1)); end
  endtask

`ifdef NIBBLE_RX_PARITY_EN
  task automatic test_parity();
    int p;
    par_flip = 1'b0;
    send_frame(4'h5, 1'b1, p);
    tick(2);
    n_cmp++; if (load_hist[p + LoadLat] !== 1'b1) begin
      n_bad++; $display("FAIL par_good_load got %0b want 1", load_hist[p + LoadLat]); end
    n_cmp++; if (bus.d !== 4'h5) begin n_bad++; $display("FAIL par_good_d got %0h want 5", bus.d); end
    par_flip = 1'b1;
    send_frame(4'h7, 1'b1, p);
    tick(2);
    par_flip = 1'b0;
    n_cmp++; if (err_hist[p + LoadLat] !== 1'b1) begin
      n_bad++; $display("FAIL par_bad_err got %0b want 1", err_hist[p + LoadLat]); end
    n_cmp++; if (count_load(p, cyc - 1) !== 0) begin
      n_bad++; $display("FAIL par_bad_load got %0d want 0", count_load(p, cyc - 1)); end
    n_cmp++; if (bus.d !== 4'h5) begin n_bad++; $display("FAIL par_bad_d got %0h want 5", bus.d); end
  endtask
`endif

  task automatic test_exclusive();
    int both = 0;
    for (int i = 0; i < cyc && i < HistLen; i++)
      if (load_hist[i] === 1'b1 && err_hist[i] === 1'b1) both++;
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL load_err_overlap got %0d want 0", both); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
`ifdef NIBBLE_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
